// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings and widths for the data-memory responder
package dm_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int STRB_W = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    typedef enum logic [1:0] {ST_IDLE = IDLE, ST_WAIT = WAIT, ST_RESP = RESP} state_e;
endpackage

// File: rtl/dm_array.sv
// dm_array: DEPTHx32 storage with byte-enabled synchronous write and registered read
// Ports: clk, reset (async, clears rd_o only), wr_en_i/rd_en_i/rd_clr_i strobes,
//        addr_i word index, wstrb_i lane enables, wd_i write data, rd_o read register
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              rd_clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++)
            if (wr_en_i && wstrb_i[i]) mem_q[addr_i][8*i +: 8] <= wd_i[8*i +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_q <= '0;
        else if (rd_clr_i) rd_q <= '0;
        else if (rd_en_i) rd_q <= mem_q[addr_i];
    end

    assign rd_o = rd_q;
endmodule

// File: rtl/dm_responder.sv
// dm_responder: req/ack data-memory responder with fixed wait states and byte strobes
// Ports: clk, reset (async, active-high); req/address/we/wstrb/wd request side;
//        ack (1-cycle pulse), rd (load data, held), err (out of range), busy
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [31:0]       address,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wd,
    output logic              ack,
    output logic [DATA_W-1:0] rd,
    output logic              err,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;
    logic              fire, in_range;

    // The counter runs down to zero in WAIT so the RESP-entry edge lands
    // WAIT_CYCLES+1 edges after capture, including WAIT_CYCLES=0.
    assign fire     = (state_q == ST_WAIT) && (cnt_q == '0);
    assign in_range = (addr_q >> (ADDR_W + 2)) == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (req) begin
                addr_d  = address;
                we_d    = we;
                wstrb_d = wstrb;
                wd_d    = wd;
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = ST_WAIT;
            end
            ST_WAIT: if (fire) begin
                state_d = ST_RESP;
                err_d   = ~in_range;
            end else cnt_d = cnt_q - CNT_W'(1);
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    dm_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (fire && we_q && in_range),
        .rd_en_i  (fire && !we_q && in_range),
        .rd_clr_i (fire && !we_q && !in_range),
        .addr_i   (addr_q[ADDR_W+1:2]),
        .wstrb_i  (wstrb_q),
        .wd_i     (wd_q),
        .rd_o     (rd)
    );

    assign ack  = state_q == ST_RESP;
    assign busy = state_q != ST_IDLE;
    assign err  = err_q;
endmodule
